// File: rtl/sprite_draw_queue_if.sv
// Command-bus and stencil-launch handshake bundle for sprite_draw_queue.
// master = game logic plus stencil side, slave = the queue itself.
interface sprite_draw_queue_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [X_WIDTH-1:0] cmd_x;
    logic [Y_WIDTH-1:0] cmd_y;
    logic [X_WIDTH-1:0] stencil_x;
    logic [Y_WIDTH-1:0] stencil_y;
    logic               stencil_we;
    logic               stencil_finish;

    modport master (
        output cmd_valid, cmd_x, cmd_y, stencil_finish,
        input  cmd_ready, stencil_x, stencil_y, stencil_we
    );
    modport slave (
        input  cmd_valid, cmd_x, cmd_y, stencil_finish,
        output cmd_ready, stencil_x, stencil_y, stencil_we
    );
endinterface

// File: rtl/sprite_draw_queue.sv
// Sprite draw FIFO plus launch sequencer feeding the stencil stage one entry at a time.
// Optional off-screen clipping: define SPRITE_DRAW_QUEUE_CLIP_EN.
module sprite_draw_queue #(
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int DEPTH         = 8,
    parameter int PTR_WIDTH     = 3,
    parameter int WE_CYCLES     = 2,
    parameter int START_TIMEOUT = 15,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int SPRITE_W      = 50,
    parameter int SPRITE_H      = 50
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sprite_draw_queue_if.slave    bus,
    output logic [PTR_WIDTH:0]    level,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [7:0]            drop_count
);
`ifdef SPRITE_DRAW_QUEUE_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam int ENTRY_W = X_WIDTH + Y_WIDTH;
    localparam int CNT_MAX = (WE_CYCLES > START_TIMEOUT) ? WE_CYCLES : START_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [X_WIDTH-1:0]   X_LIMIT    = X_WIDTH'(SCREEN_W - SPRITE_W);
    localparam logic [Y_WIDTH-1:0]   Y_LIMIT    = Y_WIDTH'(SCREEN_H - SPRITE_H);
    localparam logic [PTR_WIDTH:0]   FULL_LEVEL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [CNT_W-1:0]     WE_LAST    = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     ACK_LAST   = CNT_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, STROBE, ACK, DRAW} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [PTR_WIDTH:0]   count;
    logic                 accept, out_of_range, push, pop, timeout_hit;

    // Readiness depends only on registered occupancy, so a same-cycle pop never frees a slot.
    assign bus.cmd_ready  = (count != FULL_LEVEL);
    assign accept         = bus.cmd_valid && bus.cmd_ready;
    assign out_of_range   = (bus.cmd_x > X_LIMIT) || (bus.cmd_y > Y_LIMIT);
    assign push           = accept && !(CLIP_EN && out_of_range);
    assign level          = count;
    assign busy           = (state != IDLE);
    assign bus.stencil_we = (state == STROBE);

    // NOTE: the entry array has no reset; only pointers and count define which slots are valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {bus.cmd_x, bus.cmd_y};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.stencil_x <= '0;
            bus.stencil_y <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop) begin
                rd_ptr                       <= rd_ptr + PTR_WIDTH'(1);
                {bus.stencil_x, bus.stencil_y} <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_WIDTH+1)'(1);
                2'b01:   count <= count - (PTR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            timeout_err <= timeout_err | timeout_hit;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                // A draw may still be running after reset, so launch only when the stencil is idle.
                if (count != '0 && bus.stencil_finish) begin
                    pop        = 1'b1;
                    cnt_next   = '0;
                    state_next = STROBE;
                end
            end
            STROBE: begin
                if (cnt == WE_LAST) begin
                    cnt_next   = '0;
                    state_next = ACK;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ACK: begin
                if (!bus.stencil_finish) begin
                    state_next = DRAW;
                end else if (cnt == ACK_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DRAW: begin
                if (bus.stencil_finish) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        if (CLIP_EN) begin : g_drop
            logic [7:0] drops;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) drops <= '0;
                else if (accept && out_of_range && drops != 8'hFF) drops <= drops + 8'd1;
            end
            assign drop_count = drops;
        end else begin : g_no_drop
            assign drop_count = '0;
        end
    endgenerate
endmodule

// File: tb/tb_sprite_draw_queue.sv
// Self-checking bench for sprite_draw_queue: a behavioural stencil model plus an
// in-order launch scoreboard derived from the accepted command stream.
module tb_sprite_draw_queue;
    localparam int X_LIM = 590;
    localparam int Y_LIM = 430;
`ifdef SPRITE_DRAW_QUEUE_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] level;
    logic       busy;
    logic       timeout_err;
    logic [7:0] drop_count;

    sprite_draw_queue_if u_if ();

    sprite_draw_queue dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (u_if),
        .level       (level),
        .busy        (busy),
        .timeout_err (timeout_err),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] exp_q[$];
    logic [19:0] launch_q[$];
    int          exp_drops = 0;

    bit          hold_low   = 1'b0;
    bit          never_ack  = 1'b0;
    int          fixed_draw = 0;
    bit          m_we_d     = 1'b0;
    bit          m_drop_pending = 1'b0;
    int          m_draw_left    = 0;

    // Stencil: drops finish one cycle after the we falling edge, keeps it low for the draw.
    initial begin : stencil_model
        u_if.stencil_finish = 1'b1;
        forever begin
            @(negedge clock);
            if (m_drop_pending) begin
                m_drop_pending = 1'b0;
                m_draw_left    = (fixed_draw > 0) ? fixed_draw : int'($urandom_range(1, 12));
            end else if (m_draw_left > 0) begin
                m_draw_left--;
            end
            if (m_we_d && u_if.stencil_we === 1'b0) begin
                launch_q.push_back({u_if.stencil_x, u_if.stencil_y});
                if (!never_ack) m_drop_pending = 1'b1;
            end
            m_we_d = (u_if.stencil_we === 1'b1);
            u_if.stencil_finish = !(hold_low || m_draw_left != 0);
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Offer one command for up to budget cycles; the model learns what the queue should do with it.
    task automatic send(input logic [9:0] x, input logic [9:0] y, input int budget, output bit ok);
        u_if.cmd_valid = 1'b1;
        u_if.cmd_x     = x;
        u_if.cmd_y     = y;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (u_if.cmd_ready === 1'b1) begin
                ok = 1'b1;
                if (CLIP && (x > X_LIM || y > Y_LIM)) begin
                    if (exp_drops < 255) exp_drops++;
                end else begin
                    exp_q.push_back({x, y});
                end
            end
            @(negedge clock);
        end
        u_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            if (busy === 1'b0 && level === 4'd0 && u_if.stencil_finish === 1'b1 &&
                launch_q.size() >= exp_q.size()) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        checks++; if (u_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", u_if.cmd_ready); end
        checks++; if (u_if.stencil_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", u_if.stencil_we); end
        checks++; if (u_if.stencil_x !== 10'd0) begin errors++; $display("FAIL rst_x got %0d want 0", u_if.stencil_x); end
        checks++; if (u_if.stencil_y !== 10'd0) begin errors++; $display("FAIL rst_y got %0d want 0", u_if.stencil_y); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", timeout_err); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rst_drops got %0d want 0", drop_count); end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL rst_release busy %b level %0d want 0 0", busy, level); end
    endtask

    task automatic test_single();
        bit ok;
        logic [19:0] got, want;
        fixed_draw = 2500;
        send(10'd100, 10'd60, 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept got 0 want 1"); end
        checks++; if (level !== 4'd1 || u_if.stencil_we !== 1'b0) begin errors++; $display("FAIL single_push level %0d we %b want 1 0", level, u_if.stencil_we); end
        @(negedge clock);
        checks++; if (u_if.stencil_we !== 1'b1 || level !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL single_pop we %b level %0d busy %b want 1 0 1", u_if.stencil_we, level, busy); end
        checks++; if (u_if.stencil_x !== 10'd100 || u_if.stencil_y !== 10'd60) begin errors++; $display("FAIL single_pos got %0d,%0d want 100,60", u_if.stencil_x, u_if.stencil_y); end
        @(negedge clock);
        checks++; if (u_if.stencil_we !== 1'b1) begin errors++; $display("FAIL single_we2 got %b want 1", u_if.stencil_we); end
        @(negedge clock);
        checks++; if (u_if.stencil_we !== 1'b0) begin errors++; $display("FAIL single_we3 got %b want 0", u_if.stencil_we); end
        repeat (2000) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_draw_busy got %b want 1", busy); end
        wait_idle(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_done busy %b level %0d want 0 0", busy, level); end
        checks++; if (launch_q.size() != exp_q.size()) begin errors++; $display("FAIL single_launches got %0d want %0d", launch_q.size(), exp_q.size()); end
        while (launch_q.size() > 0 && exp_q.size() > 0) begin
            got = launch_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL single_order got %h want %h", got, want); end
        end
        launch_q.delete(); exp_q.delete();
        fixed_draw = 0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int accepted = 0;
        logic [19:0] got, want;
        logic [9:0] x, y;
        hold_low = 1'b1;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            x = 10'(20 + 30 * i); y = 10'(10 + 40 * i);
            send(x, y, 1, ok);
            if (ok) accepted++;
        end
        checks++; if (accepted != 8) begin errors++; $display("FAIL b2b_accepts got %0d want 8", accepted); end
        checks++; if (level !== 4'd8 || u_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full level %0d ready %b want 8 0", level, u_if.cmd_ready); end
        send(10'd555, 10'd333, 5, ok);
        checks++; if (ok) begin errors++; $display("FAIL b2b_stall got accepted want stalled"); end
        hold_low = 1'b0;
        send(10'd555, 10'd333, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_ninth got stalled want accepted"); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL b2b_refill level %0d want 8", level); end
        wait_idle(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_drain busy %b level %0d want 0 0", busy, level); end
        checks++; if (launch_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_launches got %0d want %0d", launch_q.size(), exp_q.size()); end
        while (launch_q.size() > 0 && exp_q.size() > 0) begin
            got = launch_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL b2b_order got %h want %h", got, want); end
        end
        launch_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        logic [19:0] got, want;
        logic [9:0] x, y;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            x = 10'($urandom_range(0, 639));
            y = 10'($urandom_range(0, 479));
            send(x, y, 200, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_accept cmd %0d got stalled want accepted", i); end
        end
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_drain busy %b level %0d want 0 0", busy, level); end
        checks++; if (launch_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_launches got %0d want %0d", launch_q.size(), exp_q.size()); end
        while (launch_q.size() > 0 && exp_q.size() > 0) begin
            got = launch_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL rand_order got %h want %h", got, want); end
        end
        launch_q.delete(); exp_q.delete();
        checks++; if (drop_count !== 8'(exp_drops)) begin errors++; $display("FAIL rand_drops got %0d want %0d", drop_count, exp_drops); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rand_timeout got %b want 0", timeout_err); end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [19:0] got, want;
        never_ack = 1'b1;
        send(10'd300, 10'd200, 5, ok);
        @(negedge clock);
        checks++; if (u_if.stencil_we !== 1'b1) begin errors++; $display("FAIL to_launch we %b want 1", u_if.stencil_we); end
        send(10'd7, 10'd9, 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_second_accept got 0 want 1"); end
        repeat (15) @(negedge clock);
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1 || level !== 4'd1) begin errors++; $display("FAIL to_early err %b busy %b level %0d want 0 1 1", timeout_err, busy, level); end
        @(negedge clock);
        checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_fire err %b busy %b want 1 0", timeout_err, busy); end
        @(negedge clock);
        checks++; if (u_if.stencil_we !== 1'b1 || u_if.stencil_x !== 10'd7 || u_if.stencil_y !== 10'd9) begin errors++; $display("FAIL to_next we %b pos %0d,%0d want 1 7,9", u_if.stencil_we, u_if.stencil_x, u_if.stencil_y); end
        never_ack = 1'b0;
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_drain busy %b level %0d want 0 0", busy, level); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", timeout_err); end
        checks++; if (launch_q.size() != exp_q.size()) begin errors++; $display("FAIL to_launches got %0d want %0d", launch_q.size(), exp_q.size()); end
        while (launch_q.size() > 0 && exp_q.size() > 0) begin
            got = launch_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL to_order got %h want %h", got, want); end
        end
        launch_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit saw_we = 1'b0;
        bit in_draw = 1'b0;
        logic [19:0] got, want;
        fixed_draw = 200;
        for (int i = 0; i < 4; i++) send(10'(50 + i), 10'(60 + i), 5, ok);
        for (int i = 0; i < 20 && !in_draw; i++) begin
            @(negedge clock);
            if (busy === 1'b1 && u_if.stencil_finish === 1'b0) in_draw = 1'b1;
        end
        checks++; if (!in_draw) begin errors++; $display("FAIL rm_draw_reached got 0 want 1"); end
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL rm_queued got %0d want 3", level); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (u_if.stencil_we !== 1'b0 || busy !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL rm_async we %b busy %b level %0d want 0 0 0", u_if.stencil_we, busy, level); end
        checks++; if (u_if.cmd_ready !== 1'b1 || timeout_err !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL rm_status ready %b err %b drops %0d want 1 0 0", u_if.cmd_ready, timeout_err, drop_count); end
        checks++; if (u_if.stencil_x !== 10'd0 || u_if.stencil_y !== 10'd0) begin errors++; $display("FAIL rm_pos got %0d,%0d want 0,0", u_if.stencil_x, u_if.stencil_y); end
        checks++; if (launch_q.size() != 1) begin errors++; $display("FAIL rm_launched got %0d want 1", launch_q.size()); end
        if (launch_q.size() > 0 && exp_q.size() > 0) begin
            got = launch_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL rm_first got %h want %h", got, want); end
        end
        launch_q.delete(); exp_q.delete();
        exp_drops = 0;
        @(negedge clock);
        reset_n = 1'b1;
        send(10'd123, 10'd321, 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_push got 0 want 1"); end
        for (int i = 0; i < 400 && u_if.stencil_finish === 1'b0; i++) begin
            if (u_if.stencil_we !== 1'b0) saw_we = 1'b1;
            @(negedge clock);
        end
        checks++; if (saw_we) begin errors++; $display("FAIL rm_blocked we seen 1 want 0 while stencil drawing"); end
        checks++; if (u_if.stencil_finish !== 1'b1 || level !== 4'd1) begin errors++; $display("FAIL rm_pending finish %b level %0d want 1 1", u_if.stencil_finish, level); end
        fixed_draw = 0;
        wait_idle(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_drain busy %b level %0d want 0 0", busy, level); end
        checks++; if (launch_q.size() != exp_q.size()) begin errors++; $display("FAIL rm_launches got %0d want %0d", launch_q.size(), exp_q.size()); end
        while (launch_q.size() > 0 && exp_q.size() > 0) begin
            got = launch_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL rm_order got %h want %h", got, want); end
        end
        launch_q.delete(); exp_q.delete();
    endtask

    task automatic test_clip();
        bit ok;
        logic [19:0] got, want;
        send(10'd591, 10'd0, 5, ok);
        send(10'd590, 10'd430, 5, ok);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clip_drain busy %b level %0d want 0 0", busy, level); end
        checks++; if (drop_count !== 8'(exp_drops)) begin errors++; $display("FAIL clip_drops got %0d want %0d", drop_count, exp_drops); end
        checks++; if (launch_q.size() != exp_q.size()) begin errors++; $display("FAIL clip_launches got %0d want %0d", launch_q.size(), exp_q.size()); end
        while (launch_q.size() > 0 && exp_q.size() > 0) begin
            got = launch_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL clip_order got %h want %h", got, want); end
        end
        launch_q.delete(); exp_q.delete();
`ifdef SPRITE_DRAW_QUEUE_CLIP_EN
        for (int i = 0; i < 260; i++) send(10'd639, 10'd479, 2, ok);
        checks++; if (drop_count !== 8'd255 || exp_drops != 255) begin errors++; $display("FAIL clip_saturate got %0d want 255", drop_count); end
        checks++; if (level !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL clip_no_queue level %0d busy %b want 0 0", level, busy); end
`endif
    endtask

    initial begin
        reset_n        = 1'b1;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_x     = '0;
        u_if.cmd_y     = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        test_clip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
